// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcodes, funct fields,
// ALU/immediate selectors and the immediate generator.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL
   } alu_op_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] imm_gen(input logic [XLEN-1:0] ins, input imm_type_e t);
      case (t)
         IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   return {ins[31:12], 12'b0};
         IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: return {{20{ins[31]}}, ins[31:20]};
      endcase
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32 x XLEN register file: two combinational read ports, one write port,
// asynchronous active-low clear, x0 hardwired to zero.
module riscv_regfile
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [4:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [4:0]      raddr1_i,
   input  logic [4:0]      raddr2_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);

   logic [XLEN-1:0] regs_q [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I core with inline decoder, immediate generator, ALU and
// branch unit. Optional macro RISCV_MUL_EN adds the MUL instruction.
module riscv_processor
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] ProgAddress_o,
   input  logic [XLEN-1:0] ProgIn_i,
   input  logic [XLEN-1:0] DataIn_i,
   output logic [XLEN-1:0] DataAddress_o,
   output logic [XLEN-1:0] DataOut_o,
   output logic            we_o
);

   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic [6:0]      opcode, funct7;
   logic [4:0]      rd, rs1, rs2, shamt;
   logic [2:0]      funct3;
   alu_op_e         alu_op;
   imm_type_e       imm_type;
   logic            use_imm, use_pc, rf_we, is_load, is_store, is_branch, is_jal, is_jalr;
   logic            br_taken;
   logic [XLEN-1:0] imm, rs1_data, rs2_data, op_a, op_b, alu_res, rd_data;

   assign opcode = ProgIn_i[6:0];
   assign rd     = ProgIn_i[11:7];
   assign funct3 = ProgIn_i[14:12];
   assign rs1    = ProgIn_i[19:15];
   assign rs2    = ProgIn_i[24:20];
   assign funct7 = ProgIn_i[31:25];

   always_comb begin
      alu_op    = ALU_ADD;
      imm_type  = IMM_I;
      use_imm   = 1'b1;
      use_pc    = 1'b0;
      rf_we     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      case (opcode)
         OPC_LUI:    begin rf_we = 1'b1; imm_type = IMM_U; alu_op = ALU_PASSB; end
         OPC_AUIPC:  begin rf_we = 1'b1; imm_type = IMM_U; use_pc = 1'b1; end
         OPC_JAL:    begin rf_we = 1'b1; imm_type = IMM_J; is_jal = 1'b1; end
         OPC_JALR:   begin rf_we = 1'b1; is_jalr = 1'b1; end
         OPC_BRANCH: begin is_branch = 1'b1; imm_type = IMM_B; end
         OPC_LOAD:   if (funct3 == F3_WORD) begin rf_we = 1'b1; is_load = 1'b1; end
         OPC_STORE:  if (funct3 == F3_WORD) begin is_store = 1'b1; imm_type = IMM_S; end
         OPC_OPIMM:  begin
            rf_we  = 1'b1;
            alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
         end
         OPC_OP: begin
            use_imm = 1'b0;
            if ((funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))) begin
               rf_we  = 1'b1;
               alu_op = alu_from_f3(funct3, funct7[5]);
            end
`ifdef RISCV_MUL_EN
            else if ((funct7 == F7_MULDIV) && (funct3 == F3_ADD)) begin
               rf_we  = 1'b1;
               alu_op = ALU_MUL;
            end
`endif
         end
         default: ;
      endcase
   end

   assign imm   = imm_gen(ProgIn_i, imm_type);
   assign op_a  = use_pc ? pc_q : rs1_data;
   assign op_b  = use_imm ? imm : rs2_data;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = op_a - op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
         ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = XLEN'($signed(op_a) >>> shamt);
         ALU_OR:    alu_res = op_a | op_b;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_PASSB: alu_res = op_b;
`ifdef RISCV_MUL_EN
         ALU_MUL:   alu_res = op_a * op_b;
`endif
         default:   alu_res = '0;
      endcase
   end

   always_comb begin
      case (funct3)
         F3_BEQ:  br_taken = (rs1_data == rs2_data);
         F3_BNE:  br_taken = (rs1_data != rs2_data);
         F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: br_taken = (rs1_data <  rs2_data);
         F3_BGEU: br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc_q + XLEN'(4);

   // JALR reuses the ALU adder (rs1 + immI); branch/JAL targets use a separate PC adder
   always_comb begin
      pc_d = pc_plus4;
      if (is_jalr)                              pc_d = {alu_res[XLEN-1:1], 1'b0};
      else if (is_jal || (is_branch && br_taken)) pc_d = pc_q + imm;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= '0;
      else      pc_q <= pc_d;
   end

   assign rd_data = (is_jal || is_jalr) ? pc_plus4 : (is_load ? DataIn_i : alu_res);

   riscv_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we_i     (rf_we && rst),
      .waddr_i  (rd),
      .wdata_i  (rd_data),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   assign ProgAddress_o = pc_q;
   assign DataAddress_o = alu_res;
   assign DataOut_o     = rs2_data;
   assign we_o          = is_store && rst;

endmodule

// File: tb/tb_riscv_processor.sv
// Self-checking bench for riscv_processor: directed programs plus random
// programs checked against an instruction-level model (honours RISCV_MUL_EN).
module tb_riscv_processor;

   logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b1;
   logic [31:0] ProgAddress_o, ProgIn_i, DataIn_i, DataAddress_o, DataOut_o;
   logic        we_o;

   logic [31:0] imem [64];
   logic        peek_en = 1'b0;
   logic [31:0] peek_ins = '0;
   logic [31:0] dval = '0;
   logic [31:0] m_x [32];
   logic [31:0] m_pc = '0;
   int          errs = 0, checks = 0;

   always #5 if (clk_en) clk = ~clk;

   assign DataIn_i = dval;
   assign ProgIn_i = peek_en ? peek_ins :
                     ((ProgAddress_o < 32'd256) ? imem[ProgAddress_o[7:2]] : 32'h0000006F);

   riscv_processor dut (
      .clk           (clk),
      .rst           (rst),
      .ProgAddress_o (ProgAddress_o),
      .ProgIn_i      (ProgIn_i),
      .DataIn_i      (DataIn_i),
      .DataAddress_o (DataAddress_o),
      .DataOut_o     (DataOut_o),
      .we_o          (we_o)
   );

   function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
   endfunction
   function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] e_j(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction
   function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] e_u(input logic [31:0] imm, input int rd, input int opc);
      return {imm[31:12], rd[4:0], opc[6:0]};
   endfunction

   function automatic logic [31:0] fetch(input logic [31:0] a);
      return (a < 32'd256) ? imem[a[7:2]] : 32'h0000006F;
   endfunction
   function automatic logic [31:0] sra(input logic [31:0] v, input int n);
      return $signed(v) >>> n;
   endfunction
   function automatic logic [31:0] alu(input int f3, input bit alt, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         0: return alt ? a - b : a + b;
         1: return a << b[4:0];
         2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3: return (a < b) ? 32'd1 : 32'd0;
         4: return a ^ b;
         5: return alt ? sra(a, int'(b[4:0])) : a >> b[4:0];
         6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // Architectural effect of one instruction at m_pc.
   task automatic model_exec(input logic [31:0] ins, output logic [31:0] npc, output int wr,
                             output logic [31:0] wv, output bit st, output logic [31:0] sa,
                             output logic [31:0] sd);
      logic [31:0] a, b, iI, iS, iB, iU, iJ;
      int f3, f7, rd;
      bit tk;
      a  = m_x[ins[19:15]];
      b  = m_x[ins[24:20]];
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      rd = int'(ins[11:7]);
      iI = sra(ins, 20);
      iS = (sra(ins, 25) << 5) | 32'(ins[11:7]);
      iB = (sra(ins, 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      iU = ins & 32'hFFFFF000;
      iJ = (sra(ins, 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      npc = m_pc + 4; wr = 0; wv = '0; st = 1'b0; sa = a + iS; sd = b; tk = 1'b0;
      case (ins[6:0])
         7'h37: begin wr = rd; wv = iU; end
         7'h17: begin wr = rd; wv = m_pc + iU; end
         7'h6F: begin wr = rd; wv = m_pc + 4; npc = m_pc + iJ; end
         7'h67: begin wr = rd; wv = m_pc + 4; npc = (a + iI) & ~32'h1; end
         7'h63: begin
            case (f3)
               0: tk = (a == b);
               1: tk = (a != b);
               4: tk = ($signed(a) < $signed(b));
               5: tk = ($signed(a) >= $signed(b));
               6: tk = (a < b);
               7: tk = (a >= b);
               default: tk = 1'b0;
            endcase
            if (tk) npc = m_pc + iB;
         end
         7'h03: if (f3 == 2) begin wr = rd; wv = dval; end
         7'h23: if (f3 == 2) st = 1'b1;
         7'h13: begin wr = rd; wv = alu(f3, (f3 == 5) && ins[30], a, iI); end
         7'h33: begin
            if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
               wr = rd; wv = alu(f3, f7 == 32, a, b);
            end
`ifdef RISCV_MUL_EN
            else if (f7 == 1 && f3 == 0) begin wr = rd; wv = a * b; end
`endif
         end
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic peek(input int r, output logic [31:0] v);
      peek_ins = e_s(0, r, 0, 2);
      peek_en  = 1'b1;
      #1 v = DataOut_o;
      peek_en  = 1'b0;
      #1;
   endtask

   task automatic chk_reg(input int r, input logic [31:0] exp);
      logic [31:0] v;
      clk_en = 1'b0;
      peek(r, v);
      clk_en = 1'b1;
      chk($sformatf("x%0d", r), v, exp);
   endtask

   task automatic chk_model_regs();
      logic [31:0] v;
      clk_en = 1'b0;
      for (int r = 0; r < 32; r++) begin
         peek(r, v);
         chk($sformatf("rnd.x%0d", r), v, m_x[r]);
      end
      clk_en = 1'b1;
   endtask

   task automatic step(input string tag);
      logic [31:0] npc, wv, sa, sd;
      int wr;
      bit st;
      model_exec(fetch(m_pc), npc, wr, wv, st, sa, sd);
      chk({tag, ".we"}, {31'b0, we_o}, {31'b0, st});
      if (st) begin
         chk({tag, ".daddr"}, DataAddress_o, sa);
         chk({tag, ".dout"}, DataOut_o, sd);
      end
      @(posedge clk);
      #1;
      if (wr != 0) m_x[wr] = wv;
      m_pc = npc;
      chk({tag, ".pc"}, ProgAddress_o, m_pc);
   endtask

   task automatic model_reset();
      m_pc = '0;
      for (int r = 0; r < 32; r++) m_x[r] = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.pc", ProgAddress_o, 32'h0);
      chk("rst.we", {31'b0, we_o}, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0000006F;
   endtask

   function automatic logic [31:0] rand_ins();
      int k, rd, rs1, rs2, f3, f7, s;
      k   = $urandom_range(0, 12);
      rd  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      f3  = $urandom_range(0, 7);
      case (k)
         0, 1, 2: begin
            if (f3 == 1)      s = $urandom_range(0, 31);
            else if (f3 == 5) s = $urandom_range(0, 31) | ($urandom_range(0, 1) * 32'h400);
            else              s = $urandom_range(0, 4095);
            return e_i(s, rs1, f3, rd, 'h13);
         end
         3, 4, 5: begin
            s  = $urandom_range(0, 2);
            f7 = (s == 0) ? 0 : ((s == 1) ? 32 : 1);
            return e_r(f7, rs2, rs1, f3, rd);
         end
         6:  return e_u($urandom, rd, 'h37);
         7:  return e_u($urandom, rd, 'h17);
         8:  return e_s($urandom_range(0, 4095), rs2, rs1, $urandom_range(1, 2) * 2 - 2);
         9:  return e_i($urandom_range(0, 4095), rs1, 2, rd, 'h03);
         10: begin
            s = $urandom_range(0, 5);
            f3 = (s < 2) ? s : s + 2;
            return e_b(4 * $urandom_range(1, 4), rs2, rs1, f3);
         end
         11: begin
            s = $urandom_range(0, 3);
            if (s == 0) return e_j(4 * $urandom_range(1, 3), rd);
            if (s == 1) return 32'h0000000F;
            if (s == 2) return 32'h00000073;
            return {$urandom_range(0, 32'h01FFFFFF), 7'h7B};
         end
         default: return e_i(4 * $urandom_range(0, 47) + $urandom_range(0, 1), 0, 0, rd, 'h67);
      endcase
   endfunction

   initial begin
      logic [31:0] mul_exp;
      clear_imem();
      model_reset();

      // Straight-line ALU code with a not-taken branch
      imem[0] = e_i(5, 0, 0, 1, 'h13);
      imem[1] = e_i(3, 1, 0, 2, 'h13);
      imem[2] = e_b(8, 2, 1, 0);
      imem[3] = e_i(9, 0, 0, 3, 'h13);
      imem[4] = e_i(1, 3, 1, 4, 'h13);
      do_reset();
      chk("t1.pc0", ProgAddress_o, 32'h0);
      repeat (5) step("t1");
      chk("t1.pc", ProgAddress_o, 32'h14);
      chk("t1.we", {31'b0, we_o}, 32'h0);
      chk_reg(1, 32'd5);
      chk_reg(2, 32'd8);
      chk_reg(3, 32'd9);
      chk_reg(4, 32'd18);
      repeat (2) step("t1.hold");
      chk("t1.hold", ProgAddress_o, 32'h14);

      // Taken branch skips the x3 write
      imem[1] = e_i(0, 1, 0, 2, 'h13);
      do_reset();
      chk_reg(1, 32'd0);
      repeat (3) step("t2");
      chk("t2.pc", ProgAddress_o, 32'h10);
      repeat (2) step("t2");
      chk_reg(3, 32'd0);

      // Store
      clear_imem();
      imem[0] = e_i(64, 0, 0, 1, 'h13);
      imem[1] = e_s(4, 1, 1, 2);
      do_reset();
      step("t3");
      chk("t3.daddr", DataAddress_o, 32'h44);
      chk("t3.dout", DataOut_o, 32'h40);
      chk("t3.we1", {31'b0, we_o}, 32'h1);
      step("t3");
      chk("t3.we0", {31'b0, we_o}, 32'h0);

      // Load and x0 write discard
      clear_imem();
      dval = 32'hA5A55A5A;
      imem[0] = e_i(0, 0, 2, 5, 'h03);
      imem[1] = e_i(7, 0, 0, 0, 'h13);
      do_reset();
      repeat (2) step("t4");
      chk_reg(5, 32'hA5A55A5A);
      chk_reg(0, 32'h0);

      // JAL / JALR and asynchronous reset during a store
      clear_imem();
      imem[0] = e_j(8, 1);
      imem[1] = e_s(0, 1, 1, 2);
      imem[2] = e_i(0, 1, 0, 0, 'h67);
      do_reset();
      step("t5");
      chk("t5.jal", ProgAddress_o, 32'h08);
      chk_reg(1, 32'h04);
      step("t5");
      chk("t5.jalr", ProgAddress_o, 32'h04);
      chk("t5.we1", {31'b0, we_o}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("t5.rst.pc", ProgAddress_o, 32'h0);
      chk("t5.rst.we", {31'b0, we_o}, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // MUL encoding
      clear_imem();
      imem[0] = e_i(7, 0, 0, 1, 'h13);
      imem[1] = e_i(-3, 0, 0, 2, 'h13);
      imem[2] = e_i('h55, 0, 0, 3, 'h13);
      imem[3] = e_r(1, 2, 1, 0, 3);
`ifdef RISCV_MUL_EN
      mul_exp = 32'hFFFFFFEB;
`else
      mul_exp = 32'h00000055;
`endif
      do_reset();
      repeat (4) step("t6");
      chk_reg(3, mul_exp);

      // Random programs against the instruction-level model
      for (int round = 0; round < 4; round++) begin
         clear_imem();
         for (int i = 0; i < 48; i++) imem[i] = rand_ins();
         dval = $urandom;
         do_reset();
         repeat (80) step($sformatf("rnd%0d", round));
         chk_model_regs();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/riscv_processor.md
# riscv_processor

Single-cycle RV32I integer core (reduced instruction set) that fetches one instruction per clock from an external combinational program memory and accesses an external combinational data memory. It sits between the instruction ROM and the data RAM/peripheral bus. It contains the program counter, the 32×XLEN register file, the immediate generator, the ALU and the branch unit.

## Interface
- XLEN, 32, datapath, register and address width (only 32 supported)
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ProgAddress_o  out  XLEN  current PC, a byte address
- ProgIn_i  in  XLEN  instruction at ProgAddress_o, valid combinationally in the same cycle
- DataIn_i  in  XLEN  load data at DataAddress_o, valid combinationally in the same cycle
- DataAddress_o  out  XLEN  load/store byte address = rs1 + imm
- DataOut_o  out  XLEN  store data = rs2
- we_o  out  1  data write enable, high only during SW

## Operation
- Supported instructions:
  - LUI, AUIPC, JAL, JALR
  - BEQ, BNE, BLT, BGE, BLTU, BGEU
  - LW, SW
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
- Immediates are sign-extended per I/S/B/U/J formats. Shift amount is the low 5 bits of the operand. Arithmetic wraps modulo 2^32.
- Next PC:
  - PC+4 by default.
  - PC+immB for a taken branch.
  - PC+immJ for JAL.
  - (rs1+immI) with bit0 cleared for JALR.
  - JAL/JALR write PC+4 to rd.
- x0 always reads 0 and writes to it are discarded. Register reads are combinational; the write happens at the rising edge.
- LW writes DataIn_i to rd. Byte/halfword loads and stores are not supported.
- Unknown opcode, FENCE, ECALL, EBREAK: executed as NOP. No register write, we_o=0, PC+4.
- The PC does no alignment checking. A misaligned branch or JAL target is loaded as computed.
- DataAddress_o and DataOut_o are driven for every instruction (don't-care unless we_o=1). we_o is combinational from the decoded opcode.

## Timing
- Every instruction completes in exactly one cycle. There are no stalls and no handshake.
- Reset asserted (rst=0):
  - PC=0 immediately.
  - All registers cleared to 0.
  - we_o forced 0.
- First fetch is at address 0x00 in the first cycle after rst rises. At each following rising edge the PC takes its next value.
- After reset is released, N rising edges leave ProgAddress_o = 4N for straight-line code.
- Reset asserted mid-instruction aborts that instruction: no register write and no store.
- A register written by instruction k is visible to instruction k+1.
- `jal x0,0` holds the PC constant indefinitely.

## Configuration
- RISCV_MUL_EN: when defined, decodes MUL (opcode 0110011, funct7 0000001, funct3 000). rd receives the low 32 bits of rs1×rs2.
- When undefined, that encoding is a NOP.

## Structure
- Package riscv_pkg:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP)
  - funct3 constants
  - ALU operation enum
  - immediate-type enum
- Sub-module riscv_regfile: 32×XLEN, two combinational read ports, one synchronous write port, async active-low clear, x0 hardwired to 0.
- ALU, decoder and immediate generator stay inline in the top module.

## Test plan
- Program `addi x1,x0,5; addi x2,x1,3; beq x1,x2,+8; addi x3,x0,9; slli x4,x3,1`, followed by `jal x0,0` at all other addresses. 5 edges after reset release → ProgAddress_o=0x14, we_o=0, x1=5, x2=8, x3=9, x4=18.
- Change x2 to equal x1 (addi x2,x1,0) so the BEQ at 0x08 is taken → the PC after the branch is 0x10 and x3 stays 0.
- `addi x1,x0,0x40; sw x1,4(x1)` → on the SW cycle DataAddress_o=0x44, DataOut_o=0x40, we_o=1. we_o=0 on all other cycles.
- DataIn_i fixed at 0xA5A55A5A, `lw x5,0(x0)` → x5=0xA5A55A5A. `addi x0,x0,7` → x0 reads 0.
- `jal x1,+8` at 0x00 → PC=0x08, x1=0x04. `jalr x0,0(x1)` returns the PC to 0x04. Pulling rst low mid-program → PC=0 and we_o=0 immediately.
- With RISCV_MUL_EN: x1=7, x2=-3, `mul x3,x1,x2` → x3=0xFFFFFFEB. Without it → x3 unchanged.
